// File: rtl/mb_writeback_luma16x16.sv
// mb_writeback_luma16x16
//   Writes a reconstructed 16x16 luma macroblock back to frame memory one
//   16-pixel row per write. It also keeps the neighbour context that intra
//   prediction of later macroblocks needs:
//   - a top line buffer holding the bottom row of every MB column
//   - the right-hand column of the most recently completed MB
//
// Ports
//   clk, reset              sole clock, synchronous active-high reset
//   in_valid / in_ready     MB handshake; mbnumber and mb[256] (row*16+col)
//                           are captured on accept
//   wr_en/wr_addr/wr_data   row write to memory, held until wr_ready
//   wr_ready                memory accepts the current row
//   done / err              one-cycle completion pulse; err marks a bad index
//   nb_req / nb_mbnumber    neighbour query, answered one cycle later
//   nb_valid                one-cycle response strobe
//   toppixels / leftpixels  neighbour pixels for the queried MB (128 = absent)
module mb_writeback_luma16x16 #(
    parameter int LENGTH    = 1280,
    parameter int WIDTH     = 720,
    parameter int MB_SIZE_L = 16,
    parameter int MB_SIZE_W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [12:0]  mbnumber,
    input  logic [7:0]   mb [256],
    output logic         wr_en,
    output logic [19:0]  wr_addr,
    output logic [127:0] wr_data,
    input  logic         wr_ready,
    output logic         done,
    output logic         err,
    input  logic         nb_req,
    input  logic [12:0]  nb_mbnumber,
    output logic         nb_valid,
    output logic [7:0]   toppixels [16],
    output logic [7:0]   leftpixels [16]
);
    localparam int MBS_X = LENGTH / MB_SIZE_W;
    localparam int MBS_Y = WIDTH / MB_SIZE_L;
    localparam int NMB   = MBS_X * MBS_Y;
    localparam int XW    = $clog2(MBS_X);
    localparam logic [3:0]  ROW_LAST = 4'(MB_SIZE_L - 1);
    localparam logic [19:0] LEN20    = 20'(LENGTH);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;

    state_t        state_q;
    logic          in_ready_q, wr_en_q, done_q, err_q, bad_q;
    logic [19:0]   wr_addr_q;
    logic [127:0]  wr_data_q;
    logic [3:0]    row_q;
    logic [12:0]   mbnum_q, last_mb_q;
    logic [XW-1:0] mbx_q;
    logic [7:0]    mb_q [256];
    logic [7:0]    left_q [16];
    logic [MBS_X-1:0] top_vld_q;
    logic [127:0]  top_mem [MBS_X];

    logic          nb_valid_q, top_use_q, left_use_q;
    logic [127:0]  top_rd_q;
    logic [7:0]    left_rd_q [16];

    // Accept-side decode of the incoming MB index
    logic [XW-1:0] acc_x_d;
    logic [12:0]   acc_y_d;
    logic [19:0]   acc_base_d;
    logic          acc_bad_d, accept_d;
    // Query-side decode
    logic [XW-1:0] nb_x_d;
    logic [12:0]   nb_y_d;
    logic          nb_in_range_d;
    logic [3:0]    row_inc_d;
    logic [127:0]  row_in0_d, row_next_d;
    logic          top_we_d;

    assign acc_x_d    = XW'(mbnumber % MBS_X);
    assign acc_y_d    = 13'(mbnumber / MBS_X);
    assign acc_base_d = 20'(int'(acc_y_d) * MB_SIZE_L * LENGTH + int'(acc_x_d) * MB_SIZE_W);
    assign acc_bad_d  = int'(mbnumber) >= NMB;
    assign accept_d   = (state_q == S_IDLE) && in_valid && in_ready_q;

    assign nb_x_d        = XW'(nb_mbnumber % MBS_X);
    assign nb_y_d        = 13'(nb_mbnumber / MBS_X);
    assign nb_in_range_d = int'(nb_mbnumber) < NMB;

    assign row_inc_d = row_q + 4'd1;
    assign top_we_d  = !reset && (state_q == S_WRITE) && wr_en_q && wr_ready
                       && (row_q == ROW_LAST);

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_pix
            // Row 0 comes straight from the port because mb_q loads on the same edge
            assign row_in0_d[gi*8 +: 8]  = mb[gi];
            assign row_next_d[gi*8 +: 8] = mb_q[{row_inc_d, 4'(gi)}];
            assign toppixels[gi]  = top_use_q  ? top_rd_q[gi*8 +: 8] : 8'd128;
            assign leftpixels[gi] = left_use_q ? left_rd_q[gi]       : 8'd128;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            bad_q      <= 1'b0;
            row_q      <= '0;
            mbnum_q    <= '0;
            mbx_q      <= '0;
            last_mb_q  <= 13'h1FFF;
            top_vld_q  <= '0;
            for (int i = 0; i < 16; i++) left_q[i] <= 8'd128;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (accept_d) begin
                        in_ready_q <= 1'b0;
                        mbnum_q    <= mbnumber;
                        mbx_q      <= acc_x_d;
                        row_q      <= '0;
                        bad_q      <= acc_bad_d;
                        if (acc_bad_d) begin
                            state_q <= S_DONE;
                        end else begin
                            state_q   <= S_WRITE;
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= acc_base_d;
                            wr_data_q <= row_in0_d;
                        end
                    end
                end
                S_WRITE: begin
                    if (wr_en_q && wr_ready) begin
                        left_q[row_q] <= wr_data_q[127:120];
                        if (row_q == ROW_LAST) begin
                            wr_en_q          <= 1'b0;
                            state_q          <= S_DONE;
                            done_q           <= 1'b1;
                            last_mb_q        <= mbnum_q;
                            top_vld_q[mbx_q] <= 1'b1;
                        end else begin
                            row_q     <= row_inc_d;
                            wr_addr_q <= wr_addr_q + LEN20;
                            wr_data_q <= row_next_d;
                        end
                    end
                end
                S_DONE: begin
                    // A bad index arrives here with done_q low; spend one
                    // cycle raising done/err, then return like a normal MB.
                    if (done_q) begin
                        state_q    <= S_IDLE;
                        in_ready_q <= 1'b1;
                    end else begin
                        done_q <= 1'b1;
                        err_q  <= bad_q;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // MB pixel capture; data path only, no reset needed
    always_ff @(posedge clk) begin
        if (!reset && accept_d) mb_q <= mb;
    end

    // Top line buffer storage. Entries that were never written since reset are
    // masked to 128 via top_vld_q, so the array itself carries no reset.
    always_ff @(posedge clk) begin
        if (top_we_d) top_mem[mbx_q] <= wr_data_q;
        if (nb_req)   top_rd_q <= top_mem[nb_x_d];
    end

    // Neighbour response; nonblocking reads give read-before-write ordering
    always_ff @(posedge clk) begin
        if (reset) begin
            nb_valid_q <= 1'b0;
            top_use_q  <= 1'b0;
            left_use_q <= 1'b0;
            for (int i = 0; i < 16; i++) left_rd_q[i] <= 8'd128;
        end else begin
            nb_valid_q <= nb_req;
            if (nb_req) begin
                top_use_q  <= nb_in_range_d && (nb_y_d != '0) && top_vld_q[nb_x_d];
                left_use_q <= nb_in_range_d && (nb_x_d != '0)
                              && (last_mb_q == (nb_mbnumber - 13'd1));
                left_rd_q  <= left_q;
            end
        end
    end

    assign in_ready = in_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign done     = done_q;
    assign err      = err_q;
    assign nb_valid = nb_valid_q;
endmodule

// File: tb/tb_mb_writeback_luma16x16.sv
module tb_mb_writeback_luma16x16;
    localparam int MBS_X = 80;
    localparam int NMB   = 3600;
    localparam int LEN   = 1280;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [12:0]  mbnumber;
    logic [7:0]   mb [256];
    logic         wr_en;
    logic [19:0]  wr_addr;
    logic [127:0] wr_data;
    logic         wr_ready;
    logic         done, err;
    logic         nb_req;
    logic [12:0]  nb_mbnumber;
    logic         nb_valid;
    logic [7:0]   toppixels [16];
    logic [7:0]   leftpixels [16];

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference state: frame-level view of neighbour context
    logic [7:0]  top_m [MBS_X][16];
    logic [7:0]  left_m [16];
    logic [12:0] last_m;
    logic [7:0]  ref_pix [256];

    mb_writeback_luma16x16 dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .mbnumber(mbnumber), .mb(mb), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ready(wr_ready), .done(done), .err(err),
        .nb_req(nb_req), .nb_mbnumber(nb_mbnumber), .nb_valid(nb_valid),
        .toppixels(toppixels), .leftpixels(leftpixels)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int x = 0; x < MBS_X; x++)
            for (int c = 0; c < 16; c++) top_m[x][c] = 8'd128;
        for (int c = 0; c < 16; c++) left_m[c] = 8'd128;
        last_m = 13'h1FFF;
    endtask

    function automatic int addr_of(input int mbn, input int r);
        return ((mbn / MBS_X) * 16 + r) * LEN + (mbn % MBS_X) * 16;
    endfunction

    function automatic logic [127:0] row_of(input int r);
        logic [127:0] v;
        for (int c = 0; c < 16; c++) v[c*8 +: 8] = ref_pix[r*16 + c];
        return v;
    endfunction

    function automatic logic [127:0] exp_top(input int nbn);
        logic [127:0] v;
        v = {16{8'd128}};
        if (nbn < NMB && nbn / MBS_X != 0)
            for (int c = 0; c < 16; c++) v[c*8 +: 8] = top_m[nbn % MBS_X][c];
        return v;
    endfunction

    function automatic logic [127:0] exp_left(input int nbn);
        logic [127:0] v;
        logic [12:0]  prev;
        prev = 13'(nbn) - 13'd1;
        v = {16{8'd128}};
        if (nbn < NMB && nbn % MBS_X != 0 && last_m == prev)
            for (int c = 0; c < 16; c++) v[c*8 +: 8] = left_m[c];
        return v;
    endfunction

    function automatic logic [127:0] top_obs();
        logic [127:0] v;
        for (int c = 0; c < 16; c++) v[c*8 +: 8] = toppixels[c];
        return v;
    endfunction

    function automatic logic [127:0] left_obs();
        logic [127:0] v;
        for (int c = 0; c < 16; c++) v[c*8 +: 8] = leftpixels[c];
        return v;
    endfunction

    task automatic query(input int nbn);
        logic [127:0] et, el;
        et = exp_top(nbn);
        el = exp_left(nbn);
        nb_req = 1'b1;
        nb_mbnumber = 13'(nbn);
        @(posedge clk); #1;
        nb_req = 1'b0;
        nb_mbnumber = 13'($urandom);
        chk("nb_valid", nb_valid, 1);
        chk("toppixels", top_obs(), et);
        chk("leftpixels", left_obs(), el);
        $display("query nb=%0d top=%h left=%h", nbn, top_obs(), left_obs());
        @(posedge clk); #1;
        chk("nb_valid_pulse", nb_valid, 0);
    endtask

    // pat: 0 = index ramp, 1 = 0x55 fill, 2 = random
    // stall_mode: 0 none, 1 = 3 stall cycles at row 5, 2 = random stalls
    task automatic send_mb(input int mbn, input int pat, input int stall_mode,
                           input int reset_row, input bit q_last);
        int rows, cyc, stalls, stall_left, waitc, qn;
        bit rdy, qpend;
        logic [127:0] erow, qt, ql;
        for (int i = 0; i < 256; i++) begin
            case (pat)
                0:       ref_pix[i] = 8'(i);
                1:       ref_pix[i] = 8'h55;
                default: ref_pix[i] = 8'($urandom);
            endcase
            mb[i] = ref_pix[i];
        end
        waitc = 0;
        while (in_ready !== 1'b1 && waitc < 50) begin
            @(posedge clk); #1;
            waitc++;
        end
        chk("in_ready_wait", in_ready, 1);
        in_valid = 1'b1;
        mbnumber = 13'(mbn);
        @(posedge clk); #1;
        // Scramble inputs after accept: captured copy must be used
        in_valid = 1'b0;
        mbnumber = 13'($urandom);
        for (int i = 0; i < 256; i++) mb[i] = 8'($urandom);
        chk("in_ready_busy", in_ready, 0);

        if (mbn >= NMB) begin
            chk("bad_c1_wr_en", wr_en, 0);
            chk("bad_c1_done", done, 0);
            @(posedge clk); #1;
            chk("bad_done", done, 1);
            chk("bad_err", err, 1);
            chk("bad_wr_en", wr_en, 0);
            @(posedge clk); #1;
            chk("bad_done_off", done, 0);
            chk("bad_err_off", err, 0);
            chk("bad_in_ready", in_ready, 1);
            $display("MB %0d rejected with err", mbn);
            return;
        end

        rows = 0; cyc = 1; stalls = 0; stall_left = 3; qpend = 1'b0;
        qt = '0; ql = '0;
        while (rows < 16 && cyc < 400) begin
            rdy = 1'b1;
            if (stall_mode == 1 && rows == 5 && stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
            end else if (stall_mode == 2) begin
                rdy = ($urandom_range(3, 0) != 0);
            end
            wr_ready = rdy;
            if (rows == reset_row) begin
                reset = 1'b1;
                @(posedge clk); #1;
                chk("rst_wr_en", wr_en, 0);
                chk("rst_done", done, 0);
                chk("rst_in_ready", in_ready, 0);
                chk("rst_nb_valid", nb_valid, 0);
                reset = 1'b0;
                model_reset();
                @(posedge clk); #1;
                chk("post_rst_in_ready", in_ready, 1);
                chk("post_rst_wr_en", wr_en, 0);
                chk("post_rst_done", done, 0);
                wr_ready = 1'b1;
                $display("MB %0d aborted by reset at row %0d", mbn, rows);
                return;
            end
            erow = row_of(rows);
            chk("wr_en", wr_en, 1);
            chk("wr_addr", wr_addr, 128'(addr_of(mbn, rows)));
            chk("wr_data", wr_data, erow);
            chk("done_busy", done, 0);
            if (q_last && rows == 15 && rdy) begin
                qn = mbn + MBS_X;
                qt = exp_top(qn);
                ql = exp_left(qn);
                nb_req = 1'b1;
                nb_mbnumber = 13'(qn);
                qpend = 1'b1;
            end
            if (rdy) begin
                left_m[rows] = erow[127:120];
                if (rows == 15) begin
                    for (int c = 0; c < 16; c++) top_m[mbn % MBS_X][c] = erow[c*8 +: 8];
                    last_m = 13'(mbn);
                end
                rows++;
            end else begin
                stalls++;
            end
            @(posedge clk); #1;
            cyc++;
            if (qpend) begin
                nb_req = 1'b0;
                qpend = 1'b0;
                chk("rbw_nb_valid", nb_valid, 1);
                chk("rbw_top", top_obs(), qt);
                chk("rbw_left", left_obs(), ql);
            end
        end
        wr_ready = 1'b1;
        chk("rows_written", 128'(rows), 128'(16));
        chk("done_pulse", done, 1);
        chk("err_clear", err, 0);
        chk("wr_en_done", wr_en, 0);
        chk("done_cycle", 128'(cyc), 128'(17 + stalls));
        @(posedge clk); #1;
        chk("done_off", done, 0);
        chk("in_ready_back", in_ready, 1);
        $display("MB %0d written: 16 rows, %0d stalls, done at cycle %0d", mbn, stalls, cyc);
    endtask

    initial begin
        int mbn;
        reset = 1'b1; in_valid = 1'b0; mbnumber = '0; wr_ready = 1'b1;
        nb_req = 1'b0; nb_mbnumber = '0;
        for (int i = 0; i < 256; i++) mb[i] = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_nb_valid", nb_valid, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("first_in_ready", in_ready, 1);

        query(81);                       // untouched buffers: all 128
        send_mb(0, 0, 0, -1, 1'b0);      // ramp pattern, addresses 0..19200
        send_mb(0, 1, 0, -1, 1'b0);      // 0x55 fill
        query(1);
        query(80);
        send_mb(81, 2, 0, -1, 1'b0);     // 20496 .. 39696
        send_mb(82, 2, 1, -1, 1'b0);     // 3-cycle stall at row 5
        send_mb(NMB, 2, 0, -1, 1'b0);    // out-of-range index
        query(NMB);
        send_mb(1, 2, 0, -1, 1'b1);      // query of entry 1 during row 15
        query(2);

        for (int k = 0; k < 12; k++) begin
            mbn = $urandom_range(3699, 0);
            send_mb(mbn, 2, 2, -1, 1'b0);
            query(mbn + 1);
            query(mbn + MBS_X);
            query($urandom_range(3700, 0));
        end

        send_mb(0, 1, 0, 7, 1'b0);       // reset mid-MB
        query(80);
        query(1);
        send_mb(5, 2, 0, -1, 1'b0);      // recovers after reset
        query(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mb_writeback_luma16x16.md
MB_WRITEBACK_LUMA16X16 -- requirements
Module: mb_writeback_luma16x16

Interface
REQ-001 SHALL have parameter LENGTH, default 1280, meaning frame row stride in pixels.
REQ-002 SHALL have parameter WIDTH, default 720, meaning frame height in pixel rows.
REQ-003 SHALL have parameter MB_SIZE_L, default 16, meaning macroblock rows; only 16 is supported.
REQ-004 SHALL have parameter MB_SIZE_W, default 16, meaning macroblock columns; only 16 is supported.
REQ-005 SHALL have ports clk, input, 1, sole clock, and reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have ports in_valid, input, 1, MB offered, and in_ready, output, 1, MB accepted when both high.
REQ-007 SHALL have ports mbnumber, input, 13, raster MB index, and mb, input, 8 x 256 unpacked, reconstructed pixels with index = row*16 + col.
REQ-008 SHALL have ports wr_en, output, 1; wr_addr, output, 20, pixel address of row start; wr_data, output, 128, 16 pixels with col 0 in bits [7:0]; wr_ready, input, 1, memory accepts the write.
REQ-009 SHALL have ports done, output, 1, one-cycle completion pulse, and err, output, 1, one-cycle bad-index pulse.
REQ-010 SHALL have ports nb_req, input, 1; nb_mbnumber, input, 13; nb_valid, output, 1; toppixels, output, 8 x 16; leftpixels, output, 8 x 16.

Function
REQ-011 SHALL derive MBS_X = LENGTH/16 = 80, MBS_Y = WIDTH/16 = 45, and NMB = 3600; mb_x = mbnumber % MBS_X and mb_y = mbnumber / MBS_X.
REQ-012 SHALL implement the FSM IDLE -> WRITE -> DONE -> IDLE.
REQ-013 SHALL hold in_ready = 1 only in IDLE; on accept, SHALL capture mb and mbnumber into internal registers; later input changes SHALL have no effect.
REQ-014 On accept with mbnumber >= NMB, SHALL skip WRITE, go to DONE, and pulse err together with done.
REQ-015 In WRITE, SHALL issue rows r = 0..15 in order with wr_en = 1, wr_addr = (mb_y*16 + r)*LENGTH + mb_x*16, and wr_data = mb row r.
REQ-016 SHALL advance r only in a cycle where wr_en && wr_ready; otherwise wr_en, wr_addr and wr_data SHALL stay stable.
REQ-017 With wr_ready held high, SHALL set wr_en for cycles 1..16 after the accept edge and pulse done in cycle 17; accept to the next in_ready = 1 SHALL take 18 cycles.
REQ-018 wr_en SHALL be 0 in IDLE and DONE.
REQ-019 SHALL keep a top line buffer of MBS_X entries x 16 pixels; on the handshake of row 15, SHALL store that row at entry mb_x.
REQ-020 SHALL keep a left column of 16 pixels plus last_mb; on each row-r handshake, SHALL store pixel (r,15) into left[r], and on the row-15 handshake SHALL set last_mb = mbnumber.
REQ-021 A neighbour query SHALL be taken on any cycle with nb_req = 1, in any FSM state, and SHALL respond one cycle later with nb_valid = 1 for exactly one cycle.
REQ-022 For the query, toppixels SHALL be all 128 if mb_y == 0, otherwise the line buffer entry mb_x, with mb_x and mb_y taken from nb_mbnumber.
REQ-023 For the query, leftpixels SHALL be all 128 if mb_x == 0 or last_mb != nb_mbnumber - 1, otherwise left[0..15].
REQ-024 A query and a row-15 handshake in the same cycle SHALL return the pre-update buffer contents (read-before-write).
REQ-025 A query with nb_mbnumber >= NMB SHALL return all 128 on both outputs.

Reset
REQ-026 While reset = 1 at a clk edge, SHALL go to IDLE and set in_ready = 0, wr_en = 0, wr_addr = 0, wr_data = 0, done = 0, err = 0, and nb_valid = 0.
REQ-027 On reset, SHALL set all line-buffer pixels and left[] to 128 and last_mb to 13'h1FFF.
REQ-028 SHALL raise in_ready the first cycle after reset deasserts.
REQ-029 Reset during WRITE SHALL abort the MB immediately, with no further writes and no done pulse.

Verification
REQ-030 Scenario: mbnumber = 0, mb[i] = i, wr_ready = 1 -> 16 writes, wr_addr = 0, 1280, ..., 19200; row 0 wr_data bytes 00..0F; done in cycle 17.
REQ-031 Scenario: mbnumber = 81 (mb_x = 1, mb_y = 1) -> first wr_addr = 16*1280 + 16 = 20496 and last wr_addr = 31*1280 + 16 = 39696.
REQ-032 Scenario: wr_ready low for 3 cycles at row 5 -> wr_addr for row 5 is held for those 3 cycles; total of 16 writes; done is delayed 3 cycles.
REQ-033 Scenario: write MB 0 filled with 0x55, then query nb_mbnumber = 1 -> leftpixels all 0x55 and toppixels all 128; query nb_mbnumber = 80 -> toppixels all 0x55 and leftpixels all 128.
REQ-034 Scenario: mbnumber = 3600 -> no wr_en; done and err pulse together 2 cycles after accept.
REQ-035 Scenario: reset asserted at row 7 -> wr_en = 0 on the next cycle, no done pulse, and query nb_mbnumber = 80 returns toppixels all 128.
